point_draw_ctl: RTL and testbench

Sequences a single 48x64 point-image ROM (1-cycle registered read, address = {y[5:0], x[5:0]}) across up to N_POINTS on-screen point sprites. Sits in the VGA pixel pipeline between the timing/background stage and the output stage.
- Per pixel: decides which slot (if any) covers the pixel, issues the ROM address, and overlays the returned colour onto the incoming rgb.
- Timing signals are delayed to stay aligned.
- Sprite positions are written any time; they take effect only at frame start.

---
 rtl/game_pkg.sv | 15 +
 rtl/point_hit_test.sv | 32 +++
 rtl/point_draw_ctl.sv | 141 ++++++++++++++
 tb/tb_point_draw_ctl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the sprite overlay pipeline.
package game_pkg;

  localparam int          CNT_W           = 11;
  localparam int          IMG_W           = 48;
  localparam int          IMG_H           = 64;
  localparam logic [11:0] TRANSPARENT_RGB = 12'hF0F;

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             en;
  } slot_t;

endpackage

// File: rtl/point_hit_test.sv
// Per-slot coverage test: is the current pixel inside this sprite, and where.
module point_hit_test
  import game_pkg::*;
#(
  parameter int W = IMG_W,
  parameter int H = IMG_H
) (
  input  slot_t            slot,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  output logic             hit,
  output logic [5:0]       col,
  output logic [5:0]       row
);

  logic [CNT_W:0] h_ext, v_ext, x_ext, y_ext;

  // Bounds are checked one bit wider so x+W near the counter limit never wraps;
  // the low 6 bits of the offsets equal the low bits of the full difference.
  always_comb begin
    h_ext = {1'b0, hcount};
    v_ext = {1'b0, vcount};
    x_ext = {1'b0, slot.x};
    y_ext = {1'b0, slot.y};
    hit   = slot.en
            && (h_ext >= x_ext) && (h_ext < x_ext + (CNT_W+1)'(W))
            && (v_ext >= y_ext) && (v_ext < y_ext + (CNT_W+1)'(H));
    col   = hcount[5:0] - slot.x[5:0];
    row   = vcount[5:0] - slot.y[5:0];
  end

endmodule

// File: rtl/point_draw_ctl.sv
// Point-sprite overlay: picks the covering slot, addresses the shared ROM and
// composites its colour over the background with a fixed 2-clock latency.
module point_draw_ctl
  import game_pkg::*;
#(
  parameter int          N_POINTS        = 4,
  parameter int          IMG_W           = game_pkg::IMG_W,
  parameter int          IMG_H           = game_pkg::IMG_H,
  parameter logic [11:0] TRANSPARENT_RGB = game_pkg::TRANSPARENT_RGB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        pos_we,
  input  logic [2:0]  pos_idx,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        pos_en,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  slot_t shadow [N_POINTS];
  slot_t active [N_POINTS];

  logic [N_POINTS-1:0] hit_v;
  logic [5:0]          col_v [N_POINTS];
  logic [5:0]          row_v [N_POINTS];

  logic       any_hit;
  logic [5:0] sel_col, sel_row;
  logic       commit;

  logic        hit_d1, hit_d2;
  logic [5:0]  col_d1, row_d1;
  logic [10:0] hcount_d1, hcount_d2, vcount_d1, vcount_d2;
  logic        hsync_d1, hsync_d2, vsync_d1, vsync_d2;
  logic        hblnk_d1, hblnk_d2, vblnk_d1, vblnk_d2;
  logic [11:0] rgb_d1, rgb_d2;

  for (genvar g = 0; g < N_POINTS; g++) begin : g_hit
    point_hit_test #(.W(IMG_W), .H(IMG_H)) u_hit (
      .slot   (active[g]),
      .hcount (hcount_in),
      .vcount (vcount_in),
      .hit    (hit_v[g]),
      .col    (col_v[g]),
      .row    (row_v[g])
    );
  end

  // Lowest-index hitting slot wins: scan downward so lower indices overwrite.
  always_comb begin
    any_hit = 1'b0;
    sel_col = '0;
    sel_row = '0;
    for (int i = N_POINTS - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        any_hit = 1'b1;
        sel_col = col_v[i];
        sel_row = row_v[i];
      end
    end
  end

  // Positions only take effect on the rising edge of vertical blank.
  assign commit = vblnk_in & ~vblnk_d1;

  // Shadow slots take writes; active slots snapshot the pre-write shadow at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_POINTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_POINTS; i++) begin
        if (commit)
          active[i] <= shadow[i];
        if (pos_we && (pos_idx == 3'(i)))
          shadow[i] <= '{x: pos_x, y: pos_y, en: pos_en};
      end
    end
  end

  // Two-stage pipeline: stage 1 holds the hit result, stage 2 meets the ROM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_d1    <= 1'b0;  hit_d2    <= 1'b0;
      col_d1    <= '0;    row_d1    <= '0;
      hcount_d1 <= '0;    hcount_d2 <= '0;
      vcount_d1 <= '0;    vcount_d2 <= '0;
      hsync_d1  <= 1'b0;  hsync_d2  <= 1'b0;
      vsync_d1  <= 1'b0;  vsync_d2  <= 1'b0;
      hblnk_d1  <= 1'b0;  hblnk_d2  <= 1'b0;
      vblnk_d1  <= 1'b0;  vblnk_d2  <= 1'b0;
      rgb_d1    <= '0;    rgb_d2    <= '0;
    end else begin
      hit_d1    <= any_hit;    hit_d2    <= hit_d1;
      col_d1    <= sel_col;    row_d1    <= sel_row;
      hcount_d1 <= hcount_in;  hcount_d2 <= hcount_d1;
      vcount_d1 <= vcount_in;  vcount_d2 <= vcount_d1;
      hsync_d1  <= hsync_in;   hsync_d2  <= hsync_d1;
      vsync_d1  <= vsync_in;   vsync_d2  <= vsync_d1;
      hblnk_d1  <= hblnk_in;   hblnk_d2  <= hblnk_d1;
      vblnk_d1  <= vblnk_in;   vblnk_d2  <= vblnk_d1;
      rgb_d1    <= rgb_in;     rgb_d2    <= rgb_d1;
    end
  end

  assign rom_addr   = hit_d1 ? {row_d1, col_d1} : 12'h000;
  assign hcount_out = hcount_d2;
  assign vcount_out = vcount_d2;
  assign hsync_out  = hsync_d2;
  assign vsync_out  = vsync_d2;
  assign hblnk_out  = hblnk_d2;
  assign vblnk_out  = vblnk_d2;

  // Blanking forces black; otherwise an opaque ROM pixel replaces the background.
  always_comb begin
    rgb_out = rgb_d2;
    if (hblnk_d2 || vblnk_d2)
      rgb_out = 12'h000;
    else if (hit_d2 && (rom_rgb != TRANSPARENT_RGB))
      rgb_out = rom_rgb;
  end

endmodule

// File: tb/tb_point_draw_ctl.sv
// Scoreboard bench for point_draw_ctl with a registered ROM model.
module tb_point_draw_ctl;

  typedef struct packed {
    logic [11:0] rgb;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        pos_we = 1'b0;
  logic [2:0]  pos_idx = '0;
  logic [10:0] pos_x = '0, pos_y = '0;
  logic        pos_en = 1'b0;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic        rom_force = 1'b0;
  logic [11:0] rom_val = '0;
  logic        chk_s0 = 1'b0, chk_s1 = 1'b0, chk_s2 = 1'b0;

  logic [11:0] addr_q[$];
  out_t        out_q[$];
  int          total = 0;
  int          bad = 0;

  point_draw_ctl #(.N_POINTS(4)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .pos_we(pos_we), .pos_idx(pos_idx), .pos_x(pos_x), .pos_y(pos_y), .pos_en(pos_en),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // ROM model: one-clock registered read, content = addr ^ 12'h5A5 unless forced.
  always @(posedge clk) rom_rgb <= rom_force ? rom_val : (rom_addr ^ 12'h5A5);

  // Marker pipeline telling the monitor which cycles carry a checked pixel.
  always @(posedge clk) begin
    chk_s1 <= chk_s0;
    chk_s2 <= chk_s1;
  end

  // Monitor: pops expected address one clock after a pixel, output two clocks after.
  always @(negedge clk) begin
    if (chk_s1) begin
      total++;
      if (addr_q.size() == 0) begin
        bad++;
        $display("FAIL addr_q_empty actual=%h", rom_addr);
      end else begin
        logic [11:0] ea;
        ea = addr_q.pop_front();
        if (rom_addr !== ea) begin
          bad++;
          $display("FAIL rom_addr actual=%h required=%h", rom_addr, ea);
        end
      end
    end
    if (chk_s2) begin
      out_t act, exp_o;
      act = '{rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out};
      total++;
      if (out_q.size() == 0) begin
        bad++;
        $display("FAIL out_q_empty actual=%h", act);
      end else begin
        exp_o = out_q.pop_front();
        if (act !== exp_o) begin
          bad++;
          $display("FAIL pixel_out actual rgb=%h h=%0d v=%0d s/b=%b%b%b%b required rgb=%h h=%0d v=%0d s/b=%b%b%b%b",
                   act.rgb, act.h, act.v, act.hs, act.vs, act.hb, act.vb,
                   exp_o.rgb, exp_o.h, exp_o.v, exp_o.hs, exp_o.vs, exp_o.hb, exp_o.vb);
        end
      end
    end
  end

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                     input logic hs, input logic vs, input logic hb, input logic vb,
                     input logic chk, input logic [11:0] ea, input logic [11:0] er);
    @(posedge clk); #1;
    hcount_in = h; vcount_in = v; rgb_in = rgb;
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    pos_we = 1'b0;
    chk_s0 = chk;
    if (chk) begin
      addr_q.push_back(ea);
      out_q.push_back('{er, h, v, hs, vs, hb, vb});
    end
  endtask

  task automatic px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                    input logic [11:0] ea, input logic [11:0] er);
    pix(h, v, rgb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ea, er);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic set_pos(input logic [2:0] idx, input logic [10:0] x, input logic [10:0] y,
                         input logic en);
    pos_we = 1'b1; pos_idx = idx; pos_x = x; pos_y = y; pos_en = en;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [10:0] x, input logic [10:0] y,
                    input logic en);
    set_pos(idx, x, y, en);
    idle(1);
  endtask

  // vblnk low, then high (the commit clock, optionally with a write), then low.
  task automatic commit_wr(input logic do_wr, input logic [2:0] idx, input logic [10:0] x,
                           input logic [10:0] y, input logic en);
    idle(1);
    pix('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    if (do_wr) set_pos(idx, x, y, en);
    idle(1);
  endtask

  task automatic commit();
    commit_wr(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic chk_eq(input string name, input logic [11:0] act, input logic [11:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    // Reset with writes pending before and during reset.
    idle(2);
    rst = 1'b0;
    set_pos(3'd0, 11'd10, 11'd10, 1'b1);
    pix(11'd12, 11'd12, 12'hFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_pos(3'd1, 11'd10, 11'd10, 1'b1);
    rst = 1'b1;
    rom_force = 1'b1; rom_val = 12'hABC;
    for (int i = 0; i < 3; i++)
      pix(11'd12, 11'd12, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    chk_eq("rst_rom_addr", rom_addr, 12'h000);
    chk_eq("rst_rgb_out", rgb_out, 12'h000);
    chk_eq("rst_hcount", {1'b0, hcount_out}, 12'h000);
    chk_eq("rst_vcount", {1'b0, vcount_out}, 12'h000);
    chk_eq("rst_sync_blank", {8'h00, hsync_out, vsync_out, hblnk_out, vblnk_out}, 12'h000);
    rst = 1'b0;
    rom_force = 1'b0;
    px(11'd15, 11'd15, 12'h456, 12'h000, 12'h456);
    commit();
    px(11'd15, 11'd15, 12'h456, 12'h000, 12'h456);
    px(11'd11, 11'd11, 12'h457, 12'h000, 12'h457);

    // Single sprite in slot 0.
    wr(3'd0, 11'd100, 11'd50, 1'b1);
    commit();
    pix(11'd110, 11'd60, 12'h111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h28A, 12'h72F);
    px(11'd99, 11'd60, 12'h222, 12'h000, 12'h222);
    px(11'd148, 11'd60, 12'h333, 12'h000, 12'h333);
    px(11'd147, 11'd113, 12'h334, 12'hFEF, 12'hA4A);
    px(11'd147, 11'd114, 12'h335, 12'h000, 12'h335);
    pix(11'd110, 11'd60, 12'h336, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h28A, 12'h000);

    // Transparency.
    rom_force = 1'b1; rom_val = 12'hF0F;
    px(11'd110, 11'd60, 12'h123, 12'h28A, 12'h123);
    idle(2);
    rom_val = 12'hABC;
    px(11'd110, 11'd60, 12'h123, 12'h28A, 12'hABC);
    idle(2);
    rom_force = 1'b0;

    // Priority between overlapping slots 0 and 2.
    wr(3'd0, 11'd180, 11'd190, 1'b1);
    wr(3'd2, 11'd190, 11'd180, 1'b1);
    commit();
    px(11'd200, 11'd200, 12'h444, 12'h294, 12'h731);
    wr(3'd0, 11'd180, 11'd190, 1'b0);
    commit();
    px(11'd200, 11'd200, 12'h444, 12'h50A, 12'h0AF);

    // Shadow vs active: mid-frame write, then a write on the commit clock.
    wr(3'd1, 11'd300, 11'd300, 1'b1);
    px(11'd310, 11'd310, 12'h555, 12'h000, 12'h555);
    commit();
    px(11'd310, 11'd310, 12'h555, 12'h28A, 12'h72F);
    commit_wr(1'b1, 3'd1, 11'd400, 11'd400, 1'b1);
    px(11'd310, 11'd310, 12'h556, 12'h28A, 12'h72F);
    px(11'd410, 11'd410, 12'h557, 12'h000, 12'h557);
    commit();
    px(11'd410, 11'd410, 12'h558, 12'h28A, 12'h72F);
    px(11'd310, 11'd310, 12'h559, 12'h000, 12'h559);

    // Edges: right edge without wrap, top row, out-of-range slot index.
    wr(3'd3, 11'd2040, 11'd500, 1'b1);
    commit();
    px(11'd2045, 11'd510, 12'h661, 12'h285, 12'h720);
    px(11'd2047, 11'd510, 12'h662, 12'h287, 12'h722);
    px(11'd3, 11'd510, 12'h663, 12'h000, 12'h663);
    wr(3'd3, 11'd600, 11'd0, 1'b1);
    wr(3'd7, 11'd700, 11'd700, 1'b1);
    commit();
    px(11'd605, 11'd0, 12'h664, 12'h005, 12'h5A0);
    px(11'd710, 11'd710, 12'h665, 12'h000, 12'h665);

    idle(4);
    chk_eq("addr_q_drained", 12'(addr_q.size()), 12'h000);
    chk_eq("out_q_drained", 12'(out_q.size()), 12'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
